fp_result_tx: RTL and testbench

Output-side wrapper for the floating-point unit. It captures each 32-bit result when the FP core pulses `doneFP` and buffers it in a small FIFO. It then transmits each result over a 32-bit output bus using a four-phase `outReady`/`outAccept` handshake. It is the transmitter counterpart of the input wrapper that loads operands A and B and issues `startFP`.

---
 rtl/fp_result_tx.sv | 133 +++++++++++++
 tb/tb_fp_result_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_tx.sv
// fp_result_tx: output-side wrapper for the floating-point unit.
// Results pulsed out of the FP core on doneFP are captured into a small
// FIFO and then sent one at a time over outBus with a four-phase
// outReady/outAccept handshake. If the FIFO is full and no word leaves on
// the same edge, the incoming result is dropped and a sticky overflow flag
// is raised.

module fp_result_tx #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             doneFP,
    input  logic [WIDTH-1:0] resultFP,
    input  logic             outAccept,
    output logic [WIDTH-1:0] outBus,
    output logic             outReady,
    output logic             busy,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;

    logic fifo_full;
    logic fifo_empty;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Decide this edge's FIFO traffic; a pop frees a slot so a push into a
    // full FIFO is still accepted when the head leaves on the same edge.
    always_comb begin
        fifo_full  = (count_q == FULL_COUNT);
        fifo_empty = (count_q == '0);
        do_pop     = (state_q == SEND) && outAccept;
        do_push    = doneFP && (!fifo_full || do_pop);
        do_drop    = doneFP && fifo_full && !do_pop;
    end

    // Next-state for FIFO storage, pointers, occupancy and the sticky flag.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | do_drop;

        if (do_push) begin
            mem_d[wr_ptr_q] = resultFP;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Handshake sequencing: present the head, wait for accept, then wait for
    // accept to drop before another word may be offered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (outAccept) begin
                    state_d = REL;
                end
            end
            REL: begin
                if (!outAccept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers; reset wipes buffered words as well as control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decode registered state only, so they never glitch with inputs.
    // The head slot cannot be rewritten while in SEND, keeping outBus stable.
    always_comb begin
        outReady = (state_q == SEND);
        outBus   = (state_q == SEND) ? mem_q[rd_ptr_q] : '0;
        busy     = (state_q != IDLE) || !fifo_empty;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_fp_result_tx.sv
// Directed testbench for fp_result_tx: each scenario task drives its own
// stimulus and checks the handshake outputs against hand-computed values.

module tb_fp_result_tx;

    logic        clk;
    logic        rst;
    logic        doneFP;
    logic [31:0] resultFP;
    logic        outAccept;
    logic [31:0] outBus;
    logic        outReady;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    fp_result_tx #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .doneFP    (doneFP),
        .resultFP  (resultFP),
        .outAccept (outAccept),
        .outBus    (outBus),
        .outReady  (outReady),
        .busy      (busy),
        .overflow  (overflow)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        doneFP    = 1'b0;
        resultFP  = '0;
        outAccept = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Waits (bounded) for outReady, captures outBus, and completes one
    // four-phase handshake with a one-cycle receiver.
    task automatic receive_word(output logic [31:0] word, output bit ok);
        int n;
        n    = 0;
        ok   = 1'b1;
        word = '0;
        while (outReady !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (outReady !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        word      = outBus;
        outAccept = 1'b1;
        step();
        outAccept = 1'b0;
        step();
    endtask

    task automatic test_reset();
        doneFP    = 1'b0;
        resultFP  = '0;
        outAccept = 1'b0;
        rst       = 1'b1;
        #3;
        checks++;
        if (outReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", outReady); end
        checks++;
        if (outBus !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h expected 00000000", outBus); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        apply_reset();
        doneFP   = 1'b1;
        resultFP = 32'h4000_0000;
        step();
        doneFP = 1'b0;
        checks++;
        if (outReady !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_early: got %b expected 0", outReady); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_captured: got %b expected 1", busy); end
        step();
        checks++;
        if (outReady !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", outReady); end
        checks++;
        if (outBus !== 32'h4000_0000) begin errors++; $display("[TB] FAIL single_bus: got %h expected 40000000", outBus); end
        outAccept = 1'b1;
        step();
        checks++;
        if (outReady !== 1'b0) begin errors++; $display("[TB] FAIL single_rel_ready: got %b expected 0", outReady); end
        checks++;
        if (outBus !== 32'h0) begin errors++; $display("[TB] FAIL single_rel_bus: got %h expected 00000000", outBus); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_rel_busy: got %b expected 1", busy); end
        outAccept = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        bit          ok;
        apply_reset();
        doneFP   = 1'b1;
        resultFP = 32'h3F80_0000;
        step();
        resultFP = 32'h4020_0000;
        step();
        doneFP = 1'b0;
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'h3F80_0000) begin errors++; $display("[TB] FAIL b2b_first: got %h (ok=%0d) expected 3f800000", w, ok); end
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'h4020_0000) begin errors++; $display("[TB] FAIL b2b_second: got %h (ok=%0d) expected 40200000", w, ok); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow: got %b expected 0", overflow); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        bit          ok;
        bit          bus_moved;
        apply_reset();
        doneFP = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            resultFP = 32'(i);
            step();
        end
        doneFP = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        bus_moved = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (outReady !== 1'b1 || outBus !== 32'h1) bus_moved = 1'b1;
            step();
        end
        checks++;
        if (bus_moved) begin errors++; $display("[TB] FAIL ovf_hold: got bus %h ready %b expected 00000001 held", outBus, outReady); end
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'h1) begin errors++; $display("[TB] FAIL ovf_first: got %h (ok=%0d) expected 00000001", w, ok); end
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'h2) begin errors++; $display("[TB] FAIL ovf_second: got %h (ok=%0d) expected 00000002", w, ok); end
        step();
        step();
        checks++;
        if (outReady !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_dropped: got ready %b busy %b expected 0 0", outReady, busy); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [31:0] w;
        bit          ok;
        apply_reset();
        doneFP   = 1'b1;
        resultFP = 32'hA;
        step();
        resultFP = 32'hB;
        step();
        doneFP = 1'b0;
        checks++;
        if (outReady !== 1'b1 || outBus !== 32'hA) begin errors++; $display("[TB] FAIL fullpop_head: got %h ready %b expected 0000000a 1", outBus, outReady); end
        doneFP    = 1'b1;
        resultFP  = 32'hC;
        outAccept = 1'b1;
        step();
        doneFP = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_overflow: got %b expected 0", overflow); end
        checks++;
        if (outReady !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_rel: got %b expected 0", outReady); end
        outAccept = 1'b0;
        step();
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'hB) begin errors++; $display("[TB] FAIL fullpop_second: got %h (ok=%0d) expected 0000000b", w, ok); end
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'hC) begin errors++; $display("[TB] FAIL fullpop_third: got %h (ok=%0d) expected 0000000c", w, ok); end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_end: got busy %b overflow %b expected 0 0", busy, overflow); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        bit          ok;
        bit          spurious;
        apply_reset();
        doneFP   = 1'b1;
        resultFP = 32'h55;
        step();
        resultFP = 32'h66;
        step();
        doneFP = 1'b0;
        checks++;
        if (outReady !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_send: got ready %b busy %b expected 1 1", outReady, busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (outReady !== 1'b0 || outBus !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got ready %b bus %h busy %b expected 0 00000000 0", outReady, outBus, busy);
        end
        step();
        rst = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (outReady !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin errors++; $display("[TB] FAIL rstmid_quiet: got activity after reset expected none"); end
        doneFP   = 1'b1;
        resultFP = 32'h77;
        step();
        doneFP = 1'b0;
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'h77) begin errors++; $display("[TB] FAIL rstmid_new: got %h (ok=%0d) expected 00000077", w, ok); end
    endtask

    task automatic test_slow_receiver();
        logic [31:0] w;
        bit          ok;
        bit          early;
        apply_reset();
        doneFP   = 1'b1;
        resultFP = 32'h11;
        step();
        resultFP = 32'h22;
        step();
        doneFP = 1'b0;
        checks++;
        if (outReady !== 1'b1 || outBus !== 32'h11) begin errors++; $display("[TB] FAIL slow_first: got %h ready %b expected 00000011 1", outBus, outReady); end
        outAccept = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (outReady !== 1'b0 || outBus !== 32'h0) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("[TB] FAIL slow_rel_hold: got ready %b bus %h expected 0 00000000", outReady, outBus); end
        outAccept = 1'b0;
        step();
        checks++;
        if (outReady !== 1'b0) begin errors++; $display("[TB] FAIL slow_idle: got %b expected 0", outReady); end
        step();
        checks++;
        if (outReady !== 1'b1 || outBus !== 32'h22) begin errors++; $display("[TB] FAIL slow_second: got %h ready %b expected 00000022 1", outBus, outReady); end
        receive_word(w, ok);
        checks++;
        if (!ok || w !== 32'h22 || busy !== 1'b0) begin errors++; $display("[TB] FAIL slow_done: got %h busy %b (ok=%0d) expected 00000022 0", w, busy, ok); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_slow_receiver();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
